// File: rtl/scan_rx.sv
// scan_rx: collects a raw byte, raw word or ASCII-hex number from the UART stream.
// Optional inter-byte timeout: define SCAN_TIMEOUT_EN.
module scan_rx #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [7:0]    d_rx,
  input  logic          vld_rx,
  output logic          rdy_rx,
  input  logic          req_rx,
  input  logic [1:0]    mode_rx,
  output logic          ack_rx,
  output logic          flag_rx,
  output logic          err_rx,
  output logic [DW-1:0] din_rx
);

  typedef enum logic [1:0] {IDLE, RECV, DONE} st_t;

  st_t           st, st_n;
  logic [1:0]    mode;
  logic [DW-1:0] acc, acc_n, din_n;
  logic          dig, dig_n;
  logic [3:0]    bcnt, bcnt_n;
  logic          wr, flag_n, err_n;
  logic          xfer, expire;
  logic          is_dig;
  logic [3:0]    nib;

  assign rdy_rx = (st == RECV);
  assign ack_rx = (st == DONE);
  assign xfer   = vld_rx && rdy_rx;

  // ASCII hex digit to nibble
  always_comb begin
    is_dig = 1'b1;
    nib    = 4'h0;
    if (d_rx >= 8'h30 && d_rx <= 8'h39)
      nib = d_rx[3:0];
    else if ((d_rx >= 8'h61 && d_rx <= 8'h66) ||
             (d_rx >= 8'h41 && d_rx <= 8'h46))
      nib = d_rx[3:0] + 4'd9;
    else
      is_dig = 1'b0;
  end

`ifdef SCAN_TIMEOUT_EN
  logic [31:0] tcnt;
  logic        tact;

  // counter only runs once a byte has arrived; a transfer wins over expiry
  assign expire = tact && !xfer && (tcnt == 32'(TIMEOUT - 2));

  // cycles elapsed since the last accepted byte
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tcnt <= '0;
      tact <= 1'b0;
    end else if (st != RECV) begin
      tcnt <= '0;
      tact <= 1'b0;
    end else if (xfer) begin
      tcnt <= '0;
      tact <= 1'b1;
    end else if (tact) begin
      tcnt <= tcnt + 32'd1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) st <= IDLE;
    else       st <= st_n;
  end

  // next state, accumulator update and result selection
  always_comb begin
    st_n   = st;
    acc_n  = acc;
    dig_n  = dig;
    bcnt_n = bcnt;
    wr     = 1'b0;
    din_n  = acc;
    flag_n = 1'b0;
    err_n  = 1'b0;
    case (st)
      IDLE: begin
        if (req_rx) begin
          st_n   = RECV;
          acc_n  = '0;
          dig_n  = 1'b0;
          bcnt_n = '0;
        end
      end
      RECV: begin
        if (xfer) begin
          if (mode == 2'b00) begin
            din_n = DW'(d_rx);
            wr    = 1'b1;
            st_n  = DONE;
          end else if (mode == 2'b01) begin
            acc_n  = (acc << 8) | DW'(d_rx);
            bcnt_n = bcnt + 4'd1;
            if (bcnt == 4'(DW/8 - 1)) begin
              din_n = acc_n;
              wr    = 1'b1;
              st_n  = DONE;
            end
          end else if (d_rx == 8'h0A) begin
            acc_n = acc;
          end else if (d_rx == 8'h20 && !dig) begin
            acc_n = acc;
          end else if (is_dig) begin
            acc_n = (acc << 4) | DW'(nib);
            dig_n = 1'b1;
          end else if (d_rx == 8'h20 || d_rx == 8'h0D) begin
            din_n  = dig ? acc : '0;
            flag_n = !dig;
            wr     = 1'b1;
            st_n   = DONE;
          end else begin
            err_n = 1'b1;
            wr    = 1'b1;
            st_n  = DONE;
          end
        end else if (expire) begin
          err_n = 1'b1;
          wr    = 1'b1;
          st_n  = DONE;
        end
      end
      DONE:    st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  // working registers and mode latch
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc  <= '0;
      dig  <= 1'b0;
      bcnt <= '0;
      mode <= 2'b00;
    end else begin
      acc  <= acc_n;
      dig  <= dig_n;
      bcnt <= bcnt_n;
      if (st == IDLE && req_rx) mode <= mode_rx;
    end
  end

  // result registers: hold until written or cleared by a new request
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      din_rx  <= '0;
      flag_rx <= 1'b0;
      err_rx  <= 1'b0;
    end else if (wr) begin
      din_rx  <= din_n;
      flag_rx <= flag_n;
      err_rx  <= err_n;
    end else if (st == IDLE && req_rx) begin
      flag_rx <= 1'b0;
      err_rx  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scan_rx.sv
// tb_scan_rx: directed and random requests against a stream-level model.
// Timeout case is built only with SCAN_TIMEOUT_EN.
module tb_scan_rx;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [7:0]    d_rx = 8'h00;
  logic          vld_rx = 1'b0;
  logic          rdy_rx;
  logic          req_rx = 1'b0;
  logic [1:0]    mode_rx = 2'b00;
  logic          ack_rx;
  logic          flag_rx;
  logic          err_rx;
  logic [DW-1:0] din_rx;

  int tests = 0;
  int fails = 0;
  logic [7:0] q[$];
  logic [DW-1:0] r_din;
  logic r_flag, r_err;

  scan_rx #(.DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .d_rx(d_rx), .vld_rx(vld_rx), .rdy_rx(rdy_rx),
    .req_rx(req_rx), .mode_rx(mode_rx),
    .ack_rx(ack_rx), .flag_rx(flag_rx),
    .err_rx(err_rx), .din_rx(din_rx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return -1;
  endfunction

  // Reference: interpret the pending stream q as the scanner would.
  // An unterminated stream means the request ends by timeout.
  function automatic void model(input logic [1:0] m,
      output logic [63:0] v, output logic f, output logic e,
      output int n, output int lat);
    logic [63:0] val, mask;
    int nd, h;
    mask = (DW == 64) ? '1 : ((64'd1 << DW) - 64'd1);
    val = 0; nd = 0; f = 0; e = 0; lat = 1;
    if (m == 2'b00) begin
      v = {56'd0, q[0]}; n = 1; return;
    end
    if (m == 2'b01) begin
      n = 0;
      for (int k = 0; k < DW/8 && k < q.size(); k++) begin
        val = (val * 256 + {56'd0, q[k]}) & mask; n++;
      end
      v = val;
      if (n < DW/8) begin e = 1; lat = TO; end
      return;
    end
    n = 0;
    for (int k = 0; k < q.size(); k++) begin
      n = k + 1;
      h = hexval(q[k]);
      if (q[k] == 8'h0A) continue;
      if (q[k] == 8'h20 && nd == 0) continue;
      if (h >= 0) begin
        val = (val * 16 + 64'(h)) & mask; nd++; continue;
      end
      if (q[k] == 8'h20 || q[k] == 8'h0D) begin
        f = (nd == 0); v = val; return;
      end
      e = 1; v = val; return;
    end
    e = 1; v = val; lat = TO;
  endfunction

  task automatic do_req(input logic [1:0] m, input string tag,
                        input bit gaps);
    logic [63:0] ev;
    logic ef, ee, took, seen, stable;
    int en, elat, n, cyc, last;
    logic [DW-1:0] pd;
    model(m, ev, ef, ee, en, elat);
    pd = din_rx;
    req_rx = 1'b1; mode_rx = m;
    vld_rx = (q.size() > 0);
    d_rx = (q.size() > 0) ? q[0] : 8'h00;
    @(posedge clk); #1;
    req_rx = 1'b0;
    chk({tag, "_rdy"}, {63'd0, rdy_rx}, 64'd1);
    chk({tag, "_clr"}, {62'd0, flag_rx, err_rx}, 64'd0);
    n = 0; cyc = 0; last = 0; seen = 0; stable = 1;
    while (!seen && cyc < 300) begin
      vld_rx = (q.size() > 0) && (!gaps || $urandom_range(3) != 0);
      d_rx = (q.size() > 0) ? q[0] : 8'h00;
      took = vld_rx && rdy_rx;
      @(posedge clk); #1; cyc++;
      if (took) begin void'(q.pop_front()); n++; last = cyc; end
      if (ack_rx) seen = 1;
      else if (din_rx !== pd) stable = 0;
    end
    vld_rx = 1'b0;
    chk({tag, "_ack"}, {63'd0, seen}, 64'd1);
    chk({tag, "_stable"}, {63'd0, stable}, 64'd1);
    chk({tag, "_lat"}, 64'(cyc - last + 1), 64'(elat));
    chk({tag, "_used"}, 64'(n), 64'(en));
    chk({tag, "_din"}, 64'(din_rx), ev);
    chk({tag, "_flag"}, {63'd0, flag_rx}, {63'd0, ef});
    chk({tag, "_err"}, {63'd0, err_rx}, {63'd0, ee});
    chk({tag, "_rdyoff"}, {63'd0, rdy_rx}, 64'd0);
    r_din = din_rx; r_flag = flag_rx; r_err = err_rx;
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {63'd0, ack_rx}, 64'd0);
    chk({tag, "_hold"}, 64'(din_rx), 64'(r_din));
  endtask

  task automatic push_str(input string s);
    for (int k = 0; k < s.len(); k++) q.push_back(s[k]);
  endtask

  initial begin
    string al;
    int len;
    logic [1:0] m;
    al = " 0123456789abcdefABCDEF\n";

    #12;
    chk("rst_out", {rdy_rx, ack_rx, flag_rx, err_rx, din_rx}, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    q = '{8'h5A};
    do_req(2'b00, "byte", 0);
    chk("byte_const", 64'(r_din), 64'h5A);

    q = '{8'h12, 8'h34, 8'h56, 8'h78};
    do_req(2'b01, "word", 0);
    chk("word_const", 64'(r_din), 64'h12345678);

    q.delete(); push_str(" 1aF\r\n");
    do_req(2'b10, "hex", 0);
    chk("hex_const", 64'(r_din), 64'h1AF);
    chk("hex_left", 64'(q.size()), 64'd1);
    push_str("\r");
    do_req(2'b10, "empty", 0);
    chk("empty_const", {r_flag, r_din}, {1'b1, 32'd0});

    q.delete(); push_str("123456789 ");
    do_req(2'b11, "ovf", 0);
    chk("ovf_const", 64'(r_din), 64'h23456789);

    q.delete(); push_str("12G");
    do_req(2'b10, "bad", 0);
    chk("bad_const", {r_err, r_din}, {1'b1, 32'h12});

    q = '{8'hA1, 8'hB2};
    req_rx = 1'b1; mode_rx = 2'b01;
    @(posedge clk); #1;
    req_rx = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vld_rx = 1'b1; d_rx = q[0];
      @(posedge clk); #1;
      void'(q.pop_front());
    end
    vld_rx = 1'b0;
    rstn = 1'b0; #1;
    chk("mid_rst", {rdy_rx, ack_rx, flag_rx, err_rx, din_rx}, 0);
    @(posedge clk); #1;
    chk("mid_noack", {63'd0, ack_rx}, 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_req(2'b01, "after_rst", 0);
    chk("after_const", 64'(r_din), 64'hDEADBEEF);

    for (int t = 0; t < 24; t++) begin
      q.delete();
      m = 2'($urandom_range(3));
      if (m == 2'b00) q.push_back(8'($urandom));
      else if (m == 2'b01)
        for (int k = 0; k < DW/8; k++) q.push_back(8'($urandom));
      else begin
        len = $urandom_range(11);
        for (int k = 0; k < len; k++)
          q.push_back(al[$urandom_range(al.len() - 1)]);
        case ($urandom_range(3))
          0: push_str(" \r");
          1: push_str("\r");
          2: push_str("x");
          default: push_str("\t");
        endcase
      end
      do_req(m, $sformatf("rnd%0d", t), 1);
    end

`ifdef SCAN_TIMEOUT_EN
    q.delete(); push_str("7");
    do_req(2'b10, "tmo", 0);
    chk("tmo_const", {r_err, r_din}, {1'b1, 32'h7});
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scan_rx.md
# scan_rx

Parametrised input scanner for the serial debug unit. It sits between the UART receiver and the command controller. On request it collects one raw byte, a raw multi-byte word, or an ASCII-hex number from the received byte stream, then returns the value with empty and error status through a req/ack handshake. Result width is configurable, and hex parsing is done in hardware.

## Interface
- `DW`, default 32: result width in bits; a multiple of 8, range 8..64.
- `TIMEOUT`, default 1_000_000: inter-byte timeout in clk cycles; used only with `SCAN_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `d_rx`  in  8  received byte from the UART receiver.
- `vld_rx`  in  1  `d_rx` is valid.
- `rdy_rx`  out  1  scanner accepts a byte; a transfer happens when `vld_rx && rdy_rx`.
- `req_rx`  in  1  request pulse from the controller.
- `mode_rx`  in  2  request mode: 00 raw byte, 01 raw word, 10 hex number, 11 reserved (treated as 10).
- `ack_rx`  out  1  one-cycle completion pulse.
- `flag_rx`  out  1  empty: a hex request was terminated by CR before any digit.
- `err_rx`  out  1  illegal character, or timeout.
- `din_rx`  out  DW  result value.

## Operation
- Three states: IDLE, RECV, DONE.
  - IDLE → RECV on `req_rx`. `mode_rx` is latched in the same cycle. The accumulator, digit counter and byte counter are cleared. `flag_rx` and `err_rx` are cleared at this point, not before.
  - RECV → DONE when a completion condition is met. DONE → IDLE unconditionally.
- `req_rx` is sampled only in IDLE. It is ignored in RECV and DONE.
- `rdy_rx` is 1 exactly while in RECV.
- Raw byte mode: the first accepted byte becomes the result, `din_rx = {0, d_rx}`. Go to DONE.
- Raw word mode: accept DW/8 bytes. Each byte is shifted in at the LSB, so the first byte ends up most significant. Go to DONE after the last byte.
- Hex mode, per accepted byte:
  - 0x20 with no digits yet: skip.
  - 0x0A: always ignored.
  - 0-9, a-f, A-F: `acc = {acc[DW-5:0], nibble}`. Digits beyond DW/4 silently drop the oldest nibble.
  - 0x20 or 0x0D with at least one digit: go to DONE, `flag_rx = 0`.
  - 0x0D with no digits: go to DONE, `flag_rx = 1`, `din_rx = 0`.
  - Any other byte: go to DONE, `err_rx = 1`, `din_rx` holds the partial accumulator.
- `ack_rx` is 1 exactly in DONE.
- `din_rx`, `flag_rx` and `err_rx` change only when a result is written. They are stable from `ack_rx` until the next accepted `req_rx`.
- Reset, at any time including mid-request: return to IDLE. All outputs go to 0, all counters to 0. A partial result is discarded and no `ack_rx` is issued.

## Timing
- Request at cycle 0 (IDLE): `rdy_rx` = 1 from cycle 1.
- Final byte accepted at cycle k: `ack_rx` = 1 at cycle k+1, `rdy_rx` = 0 at cycle k+1, back in IDLE at cycle k+2.
- Earliest back-to-back request: `req_rx` sampled at cycle k+2.
- At most one byte is consumed per cycle. The byte that completes a request is consumed. Nothing is consumed in DONE or IDLE; the UART must hold `vld_rx`.
- Output reset values: `rdy_rx` = 0, `ack_rx` = 0, `flag_rx` = 0, `err_rx` = 0, `din_rx` = 0.

## Configuration
- `SCAN_TIMEOUT_EN` defined:
  - In RECV, a counter counts cycles since the last accepted byte. It starts after the first accepted byte; raw byte mode never times out.
  - On reaching TIMEOUT-1 with no transfer: go to DONE, `err_rx = 1`, `flag_rx = 0`, `din_rx` = partial accumulator.
  - A transfer in the same cycle as expiry wins; the counter resets.
- `SCAN_TIMEOUT_EN` undefined: no counter; RECV waits indefinitely. The `TIMEOUT` parameter is unused.

## Test plan
- Raw byte, DW=32: req with mode 00, then byte 0x5A → one `ack_rx` 1 cycle after the transfer, `din_rx` = 0x0000005A, flag = 0, err = 0.
- Raw word, DW=32: bytes 0x12 0x34 0x56 0x78 → `din_rx` = 0x12345678. `rdy_rx` drops the cycle after the 4th byte.
- Hex: " 1aF\r\n" → `din_rx` = 0x000001AF, flag = 0. The trailing 0x0A is left unconsumed for the next request. A following "\r" request → flag = 1, `din_rx` = 0.
- Hex overflow and error: "123456789 " → `din_rx` = 0x23456789. "12G" → err = 1, `din_rx` = 0x12.
- Reset asserted mid-word after 2 bytes → all outputs 0 with no ack. A new word request then yields the correct full value.
- With `SCAN_TIMEOUT_EN` and TIMEOUT=16: hex "7" then silence → ack with err = 1, `din_rx` = 0x7, exactly 16 cycles after the transfer.
